// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for the hazard scoreboard: ID/EX hazard inputs, stall/flush
// controls back to the pipeline, and debug visibility of the scoreboard state.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                          idex_memread;
  logic [REG_ADDR_W-1:0]         idex_rt;
  logic [REG_ADDR_W-1:0]         ifid_rs;
  logic [REG_ADDR_W-1:0]         ifid_rt;
  logic                          ifid_rs_used;
  logic                          ifid_rt_used;
  logic                          mem_busy;
  logic                          branch_taken;

  logic                          pc_write;
  logic                          ifid_write;
  logic                          controls_clear;
  logic                          ifid_flush;
  logic [CNT_W-1:0]              stall_count;

  // Debug: per-register counters packed 3 bits each, decoded control mode, raw hazard.
  logic [(2**REG_ADDR_W)*3-1:0]  cnt_flat;
  logic [1:0]                    mode;
  logic                          hazard;

  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used,
           mem_busy, branch_taken,
    input  pc_write, ifid_write, controls_clear, ifid_flush, stall_count,
           cnt_flat, mode, hazard
  );

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used,
           mem_busy, branch_taken,
    output pc_write, ifid_write, controls_clear, ifid_flush, stall_count,
           cnt_flat, mode, hazard
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard scoreboard: per-register down-counters track in-flight load results
// and drive the pipeline's stall, bubble and flush controls in fixed priority.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W  = 4,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hazard_scoreboard_unit_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_STALL  = 2'd1,
    MODE_FLUSH  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  localparam int         NREGS  = 1 << REG_ADDR_W;
  localparam logic [2:0] RELOAD = 3'(LOAD_LAT - 1);

  logic [2:0]       cnt [NREGS];
  logic [NREGS-1:0] pend;
  logic             hazard;
  mode_t            mode;
  logic [CNT_W-1:0] stall_cnt;

  // A register is pending if a load to it sits in EX now or its result is still in flight.
  always_comb begin
    pend = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend[r] = (bus.idex_memread && (bus.idex_rt == REG_ADDR_W'(r))) ||
                (cnt[r] != 3'd0);
    end
    if (ZERO_EXEMPT != 0) begin
      pend[0] = 1'b0;
    end
  end

  assign hazard = (bus.ifid_rs_used && pend[bus.ifid_rs]) ||
                  (bus.ifid_rt_used && pend[bus.ifid_rt]);

  always_comb begin
    mode = MODE_RUN;
    if (bus.mem_busy) begin
      mode = MODE_FREEZE;
    end else if (bus.branch_taken) begin
      mode = MODE_FLUSH;
    end else if (hazard) begin
      mode = MODE_STALL;
    end
  end

  always_comb begin
    bus.pc_write       = 1'b1;
    bus.ifid_write     = 1'b1;
    bus.controls_clear = 1'b1;
    bus.ifid_flush     = 1'b0;
    case (mode)
      MODE_FREEZE: begin
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
      end
      MODE_FLUSH: begin
        bus.controls_clear = 1'b0;
        bus.ifid_flush     = 1'b1;
      end
      MODE_STALL: begin
        bus.pc_write       = 1'b0;
        bus.ifid_write     = 1'b0;
        bus.controls_clear = 1'b0;
      end
      default: ;
    endcase
  end

  // A fresh load overwrites any remaining count; a frozen pipeline keeps every count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= 3'd0;
      end
    end else if (!bus.mem_busy) begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.idex_memread && (bus.idex_rt == REG_ADDR_W'(r))) begin
          cnt[r] <= RELOAD;
        end else if (cnt[r] != 3'd0) begin
          cnt[r] <= cnt[r] - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (!bus.pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.cnt_flat = '0;
    for (int r = 0; r < NREGS; r++) begin
      bus.cnt_flat[r*3 +: 3] = cnt[r];
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.mode        = mode;
  assign bus.hazard      = hazard;

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-specifier width (register file holds 2**REG_ADDR_W entries).
REQ-002 SHALL have parameter LOAD_LAT, default 1, range 1..7, number of cycles a load result is unavailable to the ID stage, counted from the load's EX cycle.
REQ-003 SHALL have parameter ZERO_EXEMPT, default 1; when 1, register 0 never causes a hazard.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port idex_memread, input, 1, the instruction in EX is a load.
REQ-008 SHALL have port idex_rt, input, REG_ADDR_W, the load destination register in EX.
REQ-009 SHALL have ports ifid_rs and ifid_rt, input, REG_ADDR_W each, the source registers of the instruction in ID.
REQ-010 SHALL have ports ifid_rs_used and ifid_rt_used, input, 1 each, meaning the corresponding source is actually read.
REQ-011 SHALL have port mem_busy, input, 1, data memory not ready; the whole pipeline freezes.
REQ-012 SHALL have port branch_taken, input, 1, redirect resolved this cycle; the ID instruction is squashed.
REQ-013 SHALL have ports pc_write and ifid_write, output, 1 each, where 1 = update.
REQ-014 SHALL have port controls_clear, output, 1, where 0 = insert a bubble into ID/EX and 1 = pass controls normally.
REQ-015 SHALL have port ifid_flush, output, 1, where 1 = zero IF/ID on the next edge.
REQ-016 SHALL have port stall_count, output, CNT_W, the number of cycles with pc_write=0.

Function
REQ-017 SHALL keep a scoreboard with one down-counter of width 3 per register, cnt[r].
REQ-018 SHALL compute pend(r) = (idex_memread && idex_rt==r) || cnt[r]!=0; if ZERO_EXEMPT=1, pend(0) is forced to 0.
REQ-019 SHALL compute hazard = (ifid_rs_used && pend(ifid_rs)) || (ifid_rt_used && pend(ifid_rt)), combinationally.
REQ-020 SHALL drive outputs in strict priority order:
  - mem_busy=1: pc_write=0, ifid_write=0, controls_clear=1, ifid_flush=0.
  - else branch_taken=1: pc_write=1, ifid_write=1, controls_clear=0, ifid_flush=1.
  - else hazard=1: pc_write=0, ifid_write=0, controls_clear=0, ifid_flush=0.
  - else: pc_write=1, ifid_write=1, controls_clear=1, ifid_flush=0.
REQ-021 SHALL hold every cnt[r] unchanged on any edge where mem_busy=1.
REQ-022 Otherwise, on each edge, SHALL load cnt[idex_rt] with LOAD_LAT-1 if idex_memread=1, and SHALL decrement every other nonzero counter by 1.
REQ-023 SHALL let a new load to a register whose counter is nonzero reload that counter with LOAD_LAT-1, without adding the remaining count.
REQ-024 With LOAD_LAT=1, SHALL match the one-cycle load-use stall exactly, since no counter ever leaves 0.
REQ-025 SHALL let branch_taken not alter the scoreboard; loads already in EX or beyond still complete.
REQ-026 SHALL increment stall_count on each edge where pc_write=0, saturating at 2**CNT_W-1.
REQ-027 SHALL treat an unused source (ifid_*_used=0) as never hazarding, even if its field matches.

Reset
REQ-028 While reset_n=0, SHALL asynchronously clear all cnt[r] to 0 and stall_count to 0.
REQ-029 During and immediately after reset, SHALL have outputs follow REQ-020 with an empty scoreboard: pc_write=1, ifid_write=1, controls_clear=1, ifid_flush=0, given idle inputs.
REQ-030 SHALL, on reset assertion mid-stall, release the stall in the same cycle via the counter clear (combinational term from EX excepted).

Verification
REQ-031 LOAD_LAT=1: idex_memread=1, idex_rt=5, ifid_rs=5, rs_used=1 -> pc_write=0, controls_clear=0 for 1 cycle; next cycle (EX holds bubble) pc_write=1; stall_count=1.
REQ-032 LOAD_LAT=3: load to r7 in EX, dependent on r7 held in ID -> exactly 3 stall cycles, cnt[7] sequence 2,1,0, stall_count=3.
REQ-033 ZERO_EXEMPT=1: load to r0, ID reads r0 -> no stall; separately, load r3 with ifid_rt=3, rt_used=0 -> no stall.
REQ-034 LOAD_LAT=3, cnt[4]=2, mem_busy=1 for 2 cycles -> cnt[4] stays 2, controls_clear=1, pc_write=0; after release, 2 more hazard stalls follow.
REQ-035 branch_taken=1 coincident with hazard -> ifid_flush=1, pc_write=1, controls_clear=0; scoreboard still decrements.
REQ-036 CNT_W=4, hold mem_busy=1 for 20 cycles -> stall_count saturates at 15; then reset_n=0 -> stall_count=0 and all counters 0 immediately.
